// File: rtl/serial_pattern_gen.sv
// Multi-mode shift register: rotate, serial-in or Fibonacci LFSR, with a
// parallel load, a per-frame shift counter and a registered frame-done pulse.
module serial_pattern_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = 8'h4B,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  localparam int              CW    = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic [CW-1:0]    bit_cnt,
  output logic             frame_done
);

  localparam logic [1:0] MODE_ROTATE = 2'b00;
  localparam logic [1:0] MODE_SERIAL = 2'b01;
  localparam logic [1:0] MODE_LFSR   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [WIDTH-1:0] pattern_reg;
  logic [WIDTH-1:0] pattern_next;
  logic [CW-1:0]    cnt_reg;
  logic             done_reg;
  logic             shift;
  logic             wrap;
  logic             new_bit;

  assign shift = en && (mode != MODE_HOLD);
  assign wrap  = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    new_bit = 1'b0;
    case (mode)
      MODE_ROTATE: new_bit = pattern_reg[WIDTH-1];
      MODE_SERIAL: new_bit = serial_in;
      MODE_LFSR:   new_bit = ^(pattern_reg & TAPS);
      default:     new_bit = 1'b0;
    endcase
    pattern_next = {pattern_reg[WIDTH-2:0], new_bit};
    // An all-zero LFSR would never leave zero; reseed it instead.
    if (mode == MODE_LFSR && pattern_reg == '0) begin
      pattern_next = INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_reg <= INIT;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
    end else if (load) begin
      pattern_reg <= load_data;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
    end else if (shift) begin
      pattern_reg <= pattern_next;
      cnt_reg     <= wrap ? '0 : cnt_reg + CW'(1);
      done_reg    <= wrap;
    end else begin
      done_reg    <= 1'b0;
    end
  end

  assign serial_out   = pattern_reg[WIDTH-1];
  assign parallel_out = pattern_reg;
  assign bit_cnt      = cnt_reg;
  assign frame_done   = done_reg;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Randomized and directed bench for serial_pattern_gen against a
// behavioural model of the register, frame counter and frame pulse.
module tb_serial_pattern_gen;

  localparam int         W      = 8;
  localparam logic [7:0] INIT_V = 8'h4B;
  localparam logic [7:0] TAPS_V = 8'hB8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       serial_in = 1'b0;
  logic       serial_out;
  logic [7:0] parallel_out;
  logic [2:0] bit_cnt;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: register value, shifts into the current frame, pulse.
  logic [7:0] m_reg = INIT_V;
  int         m_cnt = 0;
  logic       m_fd  = 1'b0;

  serial_pattern_gen dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_data(load_data), .serial_in(serial_in), .serial_out(serial_out),
    .parallel_out(parallel_out), .bit_cnt(bit_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    logic b;
    if (rst) begin
      m_reg = INIT_V; m_cnt = 0; m_fd = 1'b0;
    end else if (load) begin
      m_reg = load_data; m_cnt = 0; m_fd = 1'b0;
    end else if (en && mode != 2'b11) begin
      if (mode == 2'b00)      b = m_reg[7];
      else if (mode == 2'b01) b = serial_in;
      else                    b = ^(m_reg & TAPS_V);
      if (mode == 2'b10 && m_reg == 8'h00) m_reg = INIT_V;
      else                                 m_reg = (m_reg << 1) | {7'd0, b};
      m_cnt = m_cnt + 1;
      m_fd  = (m_cnt == W);
      if (m_cnt == W) m_cnt = 0;
    end else begin
      m_fd = 1'b0;
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; en = 1'b1; mode = 2'b01;
    load_data = 8'($urandom);
    step();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    checks++;
    if (parallel_out !== INIT_V || bit_cnt !== 3'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: reg=%h cnt=%0d fd=%b, required reg=%h cnt=0 fd=0",
               parallel_out, bit_cnt, frame_done, INIT_V);
    end
  endtask

  task automatic test_rotate();
    logic [8:0] exp_so;
    int pulses;
    exp_so = 9'b010010110;
    pulses = 0;
    do_reset();
    en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (serial_out !== exp_so[8-i]) begin
        errors++;
        $display("FAIL rotate_serial_out[%0d]: got %b, required %b", i, serial_out, exp_so[8-i]);
      end
      step();
      if (frame_done === 1'b1) pulses++;
    end
    en = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL rotate_frame_pulses: got %0d, required 1", pulses);
    end
    $display("rotate: 9 shifts, frame pulses %0d", pulses);
  endtask

  task automatic test_serial_in();
    logic [7:0] bits;
    bits = 8'b10110001;
    load = 1'b1; load_data = 8'h00; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      serial_in = bits[7-i];
      step();
    end
    en = 1'b0;
    checks++;
    if (parallel_out !== 8'hB1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL serial_in: reg=%h fd=%b, required reg=b1 fd=1", parallel_out, frame_done);
    end
    $display("serial_in: reg=%h fd=%b", parallel_out, frame_done);
  endtask

  task automatic test_lfsr();
    int pulses;
    pulses = 0;
    do_reset();
    en = 1'b1; mode = 2'b10;
    for (int i = 0; i < 255; i++) begin
      step();
      if (frame_done === 1'b1) pulses++;
      checks++;
      if (parallel_out !== m_reg || parallel_out === 8'h00) begin
        errors++;
        $display("FAIL lfsr_step[%0d]: got %h, required %h (nonzero)", i, parallel_out, m_reg);
      end
    end
    en = 1'b0;
    checks++;
    if (parallel_out !== INIT_V || pulses != 31 || bit_cnt !== 3'd7) begin
      errors++;
      $display("FAIL lfsr_period: reg=%h pulses=%0d cnt=%0d, required reg=4b pulses=31 cnt=7",
               parallel_out, pulses, bit_cnt);
    end
    $display("lfsr: 255 shifts, reg=%h pulses=%0d cnt=%0d", parallel_out, pulses, bit_cnt);
  endtask

  task automatic test_lockup();
    load = 1'b1; load_data = 8'h00; mode = 2'b10; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    checks++;
    if (parallel_out !== INIT_V || bit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL lockup_escape: reg=%h cnt=%0d, required reg=4b cnt=1", parallel_out, bit_cnt);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    en = 1'b1; mode = 2'b00;
    repeat (3) step();
    load = 1'b1; load_data = 8'hF0;
    step();
    load = 1'b0; en = 1'b0;
    checks++;
    if (parallel_out !== 8'hF0 || bit_cnt !== 3'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL load_over_shift: reg=%h cnt=%0d fd=%b, required reg=f0 cnt=0 fd=0",
               parallel_out, bit_cnt, frame_done);
    end
    en = 1'b1; repeat (2) step(); en = 1'b0;
    rst = 1'b1; load = 1'b1; load_data = 8'hA5;
    step();
    rst = 1'b0; load = 1'b0;
    checks++;
    if (parallel_out !== INIT_V || bit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_over_load: reg=%h cnt=%0d, required reg=4b cnt=0", parallel_out, bit_cnt);
    end
  endtask

  task automatic test_hold();
    logic [7:0] held;
    int held_cnt;
    load = 1'b1; load_data = 8'($urandom);
    step();
    load = 1'b0; en = 1'b1; mode = 2'b00;
    repeat (8) step();
    held = m_reg; held_cnt = m_cnt;
    for (int i = 0; i < 20; i++) begin
      en   = (i < 10);
      mode = (i < 10) ? 2'b11 : 2'($urandom);
      step();
      checks++;
      if (parallel_out !== held || bit_cnt !== 3'(held_cnt) || serial_out !== held[7]
          || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: reg=%h cnt=%0d so=%b fd=%b, required reg=%h cnt=%0d so=%b fd=0",
                 i, parallel_out, bit_cnt, serial_out, frame_done, held, held_cnt, held[7]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 40) == 0);
      load      = ($urandom_range(0, 12) == 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom);
      load_data = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      serial_in = 1'($urandom);
      step();
      checks++;
      if (parallel_out !== m_reg || bit_cnt !== 3'(m_cnt) || frame_done !== m_fd
          || serial_out !== m_reg[7]) begin
        errors++;
        $display("FAIL random[%0d]: reg=%h cnt=%0d fd=%b so=%b, required reg=%h cnt=%0d fd=%b so=%b",
                 i, parallel_out, bit_cnt, frame_done, serial_out, m_reg, m_cnt, m_fd, m_reg[7]);
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_serial_in();
    test_lfsr();
    test_lockup();
    test_load_priority();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
